// File: rtl/mult_arbiter.sv
// -----------------------------------------------------------------------------
// mult_arbiter
//
// Lets two requesters share one pipe_mult. Each cycle at most one request is
// granted and started into the multiplier. An owner-tag FIFO remembers who
// issued each in-flight operation, so every product goes back to its issuer.
// flush_i kills everything in flight. The multiplier is never stalled: killed
// operations still complete and pop their tag, but they return no result.
//
// Configuration macro:
//   MULT_ARB_RR_EN  defined   : round-robin arbitration when both requesters
//                               ask in the same cycle.
//                   undefined : fixed priority, requester 0 always wins.
//
// Handshake semantics:
//   An operation is accepted in a cycle where reqN_i and gntN_o are both 1.
//   gntN_o is combinational from the current inputs. A requester that is not
//   granted keeps req/operands asserted until it sees its grant.
//   resN_valid_o is a one-cycle registered pulse with no backpressure.
//   resN_o holds its last delivered product while resN_valid_o is 0.
//
// Ports:
//   clk_i, rst_i            clock; synchronous active-high reset
//   req0_i, a0_i, b0_i      requester 0 request and operands
//   gnt0_o                  requester 0 accepted this cycle
//   req1_i, a1_i, b1_i      requester 1 request and operands
//   gnt1_o                  requester 1 accepted this cycle
//   res0_valid_o, res0_o    product return for requester 0 (registered)
//   res1_valid_o, res1_o    product return for requester 1 (registered)
//   flush_i                 kill all in-flight ops; blocks grants this cycle
//   busy_o                  owner FIFO non-empty
//   mult_start_o            start strobe to pipe_mult
//   mult_multiplier_o       operand a to pipe_mult
//   mult_multicand_o        operand b to pipe_mult
//   mult_product_i          product from pipe_mult
//   mult_done_i             done strobe from pipe_mult
// -----------------------------------------------------------------------------
module mult_arbiter #(
  parameter int BIT_WIDTH = 32,
  parameter int STAGES    = 8,
  parameter int DEPTH     = STAGES + 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req0_i,
  input  logic [BIT_WIDTH-1:0] a0_i,
  input  logic [BIT_WIDTH-1:0] b0_i,
  output logic                 gnt0_o,
  input  logic                 req1_i,
  input  logic [BIT_WIDTH-1:0] a1_i,
  input  logic [BIT_WIDTH-1:0] b1_i,
  output logic                 gnt1_o,
  output logic                 res0_valid_o,
  output logic [BIT_WIDTH-1:0] res0_o,
  output logic                 res1_valid_o,
  output logic [BIT_WIDTH-1:0] res1_o,
  input  logic                 flush_i,
  output logic                 busy_o,
  output logic                 mult_start_o,
  output logic [BIT_WIDTH-1:0] mult_multiplier_o,
  output logic [BIT_WIDTH-1:0] mult_multicand_o,
  input  logic [BIT_WIDTH-1:0] mult_product_i,
  input  logic                 mult_done_i
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  // Owner-tag FIFO: one owner bit and one killed bit per slot.
  logic [DEPTH-1:0] owner_q;
  logic [DEPTH-1:0] killed_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;

  logic full;
  logic grant_ok;
  logic push;
  logic pop;
  logic live_pop;
  logic pop_owner;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    // Explicit wrap so DEPTH need not be a power of two.
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full     = (count_q == CNT_W'(DEPTH));
  // Grants are also held off while reset is asserted so that nothing looks
  // accepted in a cycle whose FIFO push is about to be discarded.
  assign grant_ok = !rst_i && !flush_i && !full;

`ifdef MULT_ARB_RR_EN
  // last_q = 1 means requester 1 won the most recent grant, so requester 0
  // wins the next contention. Reset to 1 so requester 0 wins first.
  logic last_q;
`endif

  // ---------------------------------------------------------------------------
  // Arbitration (combinational, request cycle)
  // ---------------------------------------------------------------------------
  always_comb begin
    gnt0_o = 1'b0;
    gnt1_o = 1'b0;
    if (grant_ok) begin
      if (req0_i && req1_i) begin
`ifdef MULT_ARB_RR_EN
        gnt0_o = last_q;
        gnt1_o = ~last_q;
`else
        gnt0_o = 1'b1;
`endif
      end else begin
        gnt0_o = req0_i;
        gnt1_o = req1_i;
      end
    end
  end

  // Operand mux toward the multiplier; zero when nothing starts.
  always_comb begin
    mult_multiplier_o = '0;
    mult_multicand_o  = '0;
    if (gnt0_o) begin
      mult_multiplier_o = a0_i;
      mult_multicand_o  = b0_i;
    end else if (gnt1_o) begin
      mult_multiplier_o = a1_i;
      mult_multicand_o  = b1_i;
    end
  end

  assign mult_start_o = gnt0_o | gnt1_o;
  assign push         = gnt0_o | gnt1_o;
  // done with an empty FIFO is a stray strobe and is ignored.
  assign pop          = mult_done_i && (count_q != '0);
  assign pop_owner    = owner_q[rd_ptr_q];
  // A pop in the flush cycle belongs to a killed op even though its killed
  // bit is only being set this edge.
  assign live_pop     = pop && !killed_q[rd_ptr_q] && !flush_i;
  assign busy_o       = (count_q != '0);

`ifdef MULT_ARB_RR_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_q <= 1'b1;
    end else if (push) begin
      last_q <= gnt1_o;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Owner FIFO and result registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      owner_q      <= '0;
      killed_q     <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      res0_valid_o <= 1'b0;
      res1_valid_o <= 1'b0;
      res0_o       <= '0;
      res1_o       <= '0;
    end else begin
      // Flush kills every slot. Unoccupied slots are harmless to mark since a
      // push always rewrites the killed bit; the push assignment below comes
      // last so it wins on its own slot.
      if (flush_i) begin
        killed_q <= '1;
      end
      if (push) begin
        owner_q[wr_ptr_q]  <= gnt1_o;
        killed_q[wr_ptr_q] <= 1'b0;
        wr_ptr_q           <= ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end

      unique case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase

      res0_valid_o <= live_pop && !pop_owner;
      res1_valid_o <= live_pop && pop_owner;
      if (live_pop && !pop_owner) begin
        res0_o <= mult_product_i;
      end
      if (live_pop && pop_owner) begin
        res1_o <= mult_product_i;
      end
    end
  end

endmodule

// File: tb/tb_mult_arbiter.sv
module tb_mult_arbiter;

  localparam int W      = 32;
  localparam int STAGES = 8;
  localparam int DEPTH  = STAGES + 1;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         req0, req1, flush;
  logic [W-1:0] a0, b0, a1, b1;
  logic         gnt0, gnt1;
  logic         res0_valid, res1_valid;
  logic [W-1:0] res0, res1;
  logic         busy;
  logic         mult_start;
  logic [W-1:0] mult_a, mult_b;
  logic [W-1:0] mult_product;
  logic         mult_done;

  mult_arbiter #(.BIT_WIDTH(W), .STAGES(STAGES), .DEPTH(DEPTH)) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .req0_i            (req0),
    .a0_i              (a0),
    .b0_i              (b0),
    .gnt0_o            (gnt0),
    .req1_i            (req1),
    .a1_i              (a1),
    .b1_i              (b1),
    .gnt1_o            (gnt1),
    .res0_valid_o      (res0_valid),
    .res0_o            (res0),
    .res1_valid_o      (res1_valid),
    .res1_o            (res1),
    .flush_i           (flush),
    .busy_o            (busy),
    .mult_start_o      (mult_start),
    .mult_multiplier_o (mult_a),
    .mult_multicand_o  (mult_b),
    .mult_product_i    (mult_product),
    .mult_done_i       (mult_done)
  );

  // ---------------------------------------------------------------------------
  // pipe_mult stand-in: fixed STAGES latency, done can be withheld or forced.
  // ---------------------------------------------------------------------------
  logic [STAGES-1:0] stub_v;
  logic [W-1:0]      stub_p [STAGES];
  logic              hold_done;
  logic              force_done;

  always @(posedge clk) begin
    if (rst) begin
      stub_v <= '0;
      for (int i = 0; i < STAGES; i++) stub_p[i] <= '0;
    end else begin
      stub_v    <= {stub_v[STAGES-2:0], mult_start};
      stub_p[0] <= mult_a * mult_b;
      for (int i = 1; i < STAGES; i++) stub_p[i] <= stub_p[i-1];
    end
  end

  assign mult_done    = (stub_v[STAGES-1] & ~hold_done) | force_done;
  assign mult_product = stub_p[STAGES-1];

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  logic [W-1:0] exp_q[$];
  logic         own_q[$];
  int           due_q[$];

  int           n_cmp = 0;
  int           n_err = 0;
  int           cyc   = 0;
  int           model_cnt = 0;
  logic         sb_en = 1'b1;
  logic [W-1:0] exp_res0 = '0;
  logic [W-1:0] exp_res1 = '0;
  logic         g0e, g1e;

  typedef struct {
    logic         r0;
    logic [W-1:0] a0;
    logic [W-1:0] b0;
    logic         r1;
    logic [W-1:0] a1;
    logic [W-1:0] b1;
    logic         fl;
    logic         g0;
    logic         g1;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic r0, input logic [W-1:0] va0,
                              input logic [W-1:0] vb0, input logic r1,
                              input logic [W-1:0] va1, input logic [W-1:0] vb1,
                              input logic fl, input logic g0, input logic g1);
    vec_t v;
    v.r0 = r0; v.a0 = va0; v.b0 = vb0;
    v.r1 = r1; v.a1 = va1; v.b1 = vb1;
    v.fl = fl; v.g0 = g0;  v.g1 = g1;
    return v;
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got 0x%h, expected 0x%h",
               name, cyc, act, exp);
    end
  endtask

  // One checked cycle: inputs are already driven; compare at negedge, then
  // advance the bench model and step to just after the next posedge.
  task automatic tick();
    logic         has;
    logic         ev0, ev1;
    logic         do_pop;
    logic [W-1:0] ea, eb, prod;
    @(negedge clk);
    has = 1'b0;
    if (due_q.size() != 0) has = (due_q[0] == cyc);
    ev0 = has && !own_q[0];
    ev1 = has && own_q[0];
    chk("res0_valid", W'(res0_valid), W'(ev0));
    chk("res1_valid", W'(res1_valid), W'(ev1));
    if (has) begin
      if (own_q[0]) exp_res1 = exp_q[0];
      else          exp_res0 = exp_q[0];
      void'(exp_q.pop_front());
      void'(own_q.pop_front());
      void'(due_q.pop_front());
    end
    chk("res0", res0, exp_res0);
    chk("res1", res1, exp_res1);
    chk("busy", W'(busy), W'(model_cnt != 0));
    chk("gnt0", W'(gnt0), W'(g0e));
    chk("gnt1", W'(gnt1), W'(g1e));
    chk("mult_start", W'(mult_start), W'(g0e | g1e));
    ea = g0e ? a0 : (g1e ? a1 : '0);
    eb = g0e ? b0 : (g1e ? b1 : '0);
    chk("mult_a", mult_a, ea);
    chk("mult_b", mult_b, eb);

    do_pop = mult_done && (model_cnt != 0);
    if (rst) begin
      exp_q.delete(); own_q.delete(); due_q.delete();
      model_cnt = 0;
      exp_res0  = '0;
      exp_res1  = '0;
    end else begin
      if (flush) begin
        exp_q.delete(); own_q.delete(); due_q.delete();
      end
      if ((g0e || g1e) && sb_en) begin
        prod = ea * eb;
        exp_q.push_back(prod);
        own_q.push_back(g1e);
        due_q.push_back(cyc + STAGES + 1);
      end
      model_cnt = model_cnt + ((g0e || g1e) ? 1 : 0) - (do_pop ? 1 : 0);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic apply(input vec_t v);
    req0 = v.r0; a0 = v.a0; b0 = v.b0;
    req1 = v.r1; a1 = v.a1; b1 = v.b1;
    flush = v.fl;
    g0e = v.g0;  g1e = v.g1;
    tick();
  endtask

  task automatic idle(input int n);
    repeat (n) apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    rst = 1'b1; req0 = 0; req1 = 0; flush = 0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    hold_done = 0; force_done = 0; g0e = 0; g1e = 0;
    @(posedge clk);
    #1;
    tick();               // reset values, grants held off during reset
    rst = 1'b0;

    // Single requester 0: 2*3 returns STAGES+1 cycles after the grant.
    tbl.push_back(mk(1, 2, 3, 0, 0, 0, 0, 1, 0));
    for (int i = 0; i < STAGES + 2; i++) tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    // Single requester 1 with a negative operand: -20*5 = 0xFFFFFF9C.
    tbl.push_back(mk(0, 0, 0, 1, -32'd20, 5, 0, 0, 1));
    for (int i = 0; i < STAGES + 2; i++) tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    // Contention every cycle; requester 1 won last, so requester 0 goes first.
    for (int k = 1; k <= 6; k++) begin
`ifdef MULT_ARB_RR_EN
      tbl.push_back(mk(1, k, 3, 1, k, 5, 0, k % 2 == 1, k % 2 == 0));
`else
      tbl.push_back(mk(1, k, 3, 1, k, 5, 0, 1, 0));
`endif
    end
    for (int i = 0; i < STAGES + 2; i++) tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    // Back-to-back stream: pushes overlap pops, FIFO never fills.
    for (int k = 1; k <= 12; k++) tbl.push_back(mk(1, k, k + 1, 0, 0, 0, 0, 1, 0));
    for (int i = 0; i < STAGES + 2; i++) tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    // Three ops, flush two cycles later (grant blocked), then 7*7 survives.
    for (int k = 1; k <= 3; k++) tbl.push_back(mk(1, k, k, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 5, 5, 1, 6, 6, 1, 0, 0));
    tbl.push_back(mk(1, 7, 7, 0, 0, 0, 0, 1, 0));
    for (int i = 0; i < STAGES + 2; i++) tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    // Flush landing exactly on the done cycle of an op: its result is dropped.
    tbl.push_back(mk(1, 4, 4, 0, 0, 0, 0, 1, 0));
    for (int i = 0; i < STAGES - 1; i++) tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

    // FIFO full: done withheld, continuous req0 -> exactly DEPTH grants.
    sb_en = 1'b0;
    hold_done = 1'b1;
    for (int i = 0; i < DEPTH + 3; i++) apply(mk(1, i + 1, 2, 0, 0, 0, 0, i < DEPTH, 0));
    apply(mk(1, 1, 1, 0, 0, 0, 1, 0, 0));   // flush kills all held entries
    force_done = 1'b1;
    apply(mk(1, 1, 1, 0, 0, 0, 0, 0, 0));   // pop this cycle, still full
    force_done = 1'b0;
    apply(mk(1, 9, 9, 0, 0, 0, 0, 1, 0));   // one grant per done
    apply(mk(1, 9, 9, 0, 0, 0, 0, 0, 0));
    apply(mk(1, 9, 9, 0, 0, 0, 0, 0, 0));
    rst = 1'b1;
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    rst = 1'b0;
    hold_done = 1'b0;
    sb_en = 1'b1;
    idle(3);

    // Reset with four ops in flight: everything lost, outputs back to zero.
    for (int i = 0; i < 4; i++) apply(mk(1, i + 2, 3, 0, 0, 0, 0, 1, 0));
    idle(2);
    rst = 1'b1;
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    rst = 1'b0;
    idle(STAGES + 4);

    // Stray done with an empty FIFO.
    force_done = 1'b1;
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    force_done = 1'b0;
    idle(3);

    chk("scoreboard_drained", W'(exp_q.size()), W'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mult_arbiter.md
Name: mult_arbiter

Overview:
- Shares one pipe_mult instance between two requesters, e.g. the two issue slots of the execute stage.
- Each cycle it arbitrates and drives at most one start into the multiplier.
- It tracks in-flight ownership in a tag FIFO and routes each product back to the requester that issued it.
- A flush input supports pipeline kill: in-flight results are discarded without stalling the multiplier.

Parameters:
- BIT_WIDTH, 32, operand/product width; must match the attached pipe_mult.
- STAGES, 8, pipe_mult latency in cycles from start to done; informational, used for DEPTH default.
- DEPTH, STAGES+1, owner-tag FIFO entries; maximum operations in flight.

Ports:
- clk_i  in  1  clock, all state on posedge.
- rst_i  in  1  synchronous active-high reset.
- req0_i  in  1  requester 0 operation request.
- a0_i  in  BIT_WIDTH  requester 0 multiplier operand.
- b0_i  in  BIT_WIDTH  requester 0 multiplicand operand.
- gnt0_o  out  1  requester 0 accepted this cycle (combinational).
- req1_i / a1_i / b1_i / gnt1_o  same as above, for requester 1.
- res0_valid_o  out  1  product valid for requester 0 (registered).
- res0_o  out  BIT_WIDTH  product for requester 0.
- res1_valid_o / res1_o  same as above, for requester 1.
- flush_i  in  1  discard all in-flight operations; block grants this cycle.
- busy_o  out  1  FIFO non-empty.
- mult_start_o  out  1  to pipe_mult start_i.
- mult_multiplier_o / mult_multicand_o  out  BIT_WIDTH  to pipe_mult operands.
- mult_product_i  in  BIT_WIDTH  from pipe_mult product_o.
- mult_done_i  in  1  from pipe_mult done_o.

Behaviour:
- Interface: one clock, clk_i; reset is synchronous and active-high, rst_i.
- Reset values:
  - all gnt/res_valid outputs 0, res0_o = res1_o = 0, mult_start_o = 0, busy_o = 0.
  - FIFO empty (count = 0).
  - Round-robin pointer last = 1, so requester 0 wins the first contention.
- Grant rules, combinational in the request cycle:
  - No grant if flush_i is 1 or count == DEPTH.
  - Single requester: that requester is granted.
  - Both requesting: grant the requester not equal to last.
  - last updates on grant only.
- mult_start_o = gnt0_o | gnt1_o. The mult operand outputs mux the granted requester's a/b; they are 0 when idle.
- Every grant pushes one tag {owner id, killed = 0} into the FIFO.
- Each mult_done_i cycle pops one tag:
  - Next cycle, res<owner>_valid_o = 1 and res<owner>_o = mult_product_i, unless the tag is killed.
  - res*_o holds its last value when valid is 0.
- Latency: request granted at posedge N means the result is valid on cycle N+STAGES+1.
- Simultaneous push and pop: count unchanged, both take effect.
- flush_i: every entry currently in the FIFO is marked killed. A pop in the same cycle as flush_i is also suppressed. Killed entries still pop on their done, producing no result.
- mult_done_i with an empty FIFO: ignored, no result, count stays 0.
- Reset mid-operation: FIFO cleared, pending results lost. pipe_mult is reset by the same rst_i.
- busy_o = (count != 0), registered with the FIFO state.
- Counter and pointer wrap modulo DEPTH. DEPTH is not restricted to a power of two.

Optional Feature:
- Macro MULT_ARB_RR_EN.
- Defined: round-robin arbitration as above.
- Undefined: fixed priority, requester 0 always wins contention. The last register is removed; all other behaviour is identical.

Test Plan:
- Reset then req0 with a0=2, b0=3 for one cycle -> gnt0_o=1 that cycle; res0_valid_o=1 with res0_o=6 exactly STAGES+1 cycles later; res1_valid_o stays 0.
- Both requesting every cycle, operands req0 (k, 3) and req1 (k, 5) for k=1..6 -> grants alternate 0,1,0,1,... (MULT_ARB_RR_EN); results return in grant order with the correct owner and products 3,10,9,20,...; undefined macro -> only gnt0 for six cycles.
- req1 with a1=-20, b1=5 -> res1_o = 0xFFFFFF9C; res0_valid_o never asserts.
- Continuous requests with a stub that withholds done -> exactly DEPTH=9 grants, then gnt held 0 until the first done; one grant per done thereafter.
- Issue 3 ops, assert flush_i two cycles later, issue a 4th op (a0=7, b0=7) the cycle after flush -> no result for the first 3; res0_o = 49 delivered; gnt is 0 in the flush cycle.
- Assert rst_i with 4 ops in flight -> all outputs return to reset values next cycle; no result delivered afterwards; stray mult_done_i with an empty FIFO produces no valid.
